// File: rtl/ssd_pkg.sv
// Shared types and segment constants for the seven-segment bus capture monitor.
package ssd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CAPTURED = 2'd2
  } state_t;

  // Segment patterns with bit 0 = a, active-high (already inverted from the bus)
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_HEX [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
  };

endpackage

// File: rtl/ssd_capture_seg_to_hex.sv
// Combinational inverse of the hex-to-segment decoder: pattern -> {valid, blank, nibble}.
module seg_to_hex
  import ssd_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    blank  = (seg == SEG_BLANK);
    valid  = blank;
    nibble = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        valid  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ssd_capture.sv
// Seven-segment bus capture: settles each digit, assembles 8-digit frames, flags errors.
// Define SSD_CAP_DP_EN to add dp_out and include the decimal point in stability checks.
module ssd_capture
  import ssd_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 5
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  anode,
  input  logic [7:0]  cathode,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic [7:0]  blank,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        anode_err
`ifdef SSD_CAP_DP_EN
  ,
  output logic [7:0]  dp_out
`endif
);

`ifdef SSD_CAP_DP_EN
  localparam int CW = 8;
`else
  localparam int CW = 7;
  logic unused_dp;
  assign unused_dp = cathode[7];
`endif

  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(SETTLE_CYCLES - 1);

  logic [7:0]    anode_p0, anode_p1;
  logic [CW-1:0] cath_p0, cath_p1;

  // Stage p0: input register; stage p1: previous cycle for change detection
  always_ff @(posedge clk) begin
    anode_p0 <= anode;
    cath_p0  <= cathode[CW-1:0];
    anode_p1 <= anode_p0;
    cath_p1  <= cath_p0;
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             chg, onehot, allones, at_end, latch, bad_anode;
  logic [2:0]       idx;

  assign chg     = (anode_p0 != anode_p1) || (cath_p0 != cath_p1);
  assign onehot  = $onehot(~anode_p0);
  assign allones = &anode_p0;
  assign at_end  = (state == SETTLE) && !chg && (cnt == CNT_END);
  assign latch     = at_end && onehot;
  assign bad_anode = at_end && !onehot && !allones;

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!anode_p0[i]) idx = 3'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, CAPTURED: begin
        if (chg) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end
      end
      SETTLE: begin
        if (chg) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_END) begin
          cnt_nxt   = '0;
          state_nxt = allones ? IDLE : CAPTURED;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  logic [6:0] seg_p0;
  logic       dec_valid, dec_blank;
  logic [3:0] dec_nib;

  assign seg_p0 = ~cath_p0[6:0];

  seg_to_hex u_dec (
    .seg    (seg_p0),
    .valid  (dec_valid),
    .blank  (dec_blank),
    .nibble (dec_nib)
  );

  logic [3:0]  shadow_nib [8];
  logic [7:0]  shadow_blank;
  logic [31:0] shadow_pack;
  logic [7:0]  seen;
  logic        frame_done;

  // Shadow frame: data only, validity is carried by seen
  always_ff @(posedge clk) begin
    if (latch) begin
      shadow_nib[idx]   <= dec_nib;
      shadow_blank[idx] <= dec_blank;
    end
  end

`ifdef SSD_CAP_DP_EN
  logic [7:0] shadow_dp;
  always_ff @(posedge clk) begin
    if (latch) shadow_dp[idx] <= ~cath_p0[7];
  end
`endif

  always_comb begin
    for (int i = 0; i < 8; i++) shadow_pack[4*i +: 4] = shadow_nib[i];
  end

  assign frame_done = (seen == 8'hFF);

  // Stage p2: control state, frame publish and sticky errors
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      seen        <= '0;
      digits      <= '0;
      blank       <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      anode_err   <= 1'b0;
`ifdef SSD_CAP_DP_EN
      dp_out      <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      frame_valid <= frame_done;
      if (frame_done) begin
        digits <= shadow_pack;
        blank  <= shadow_blank;
`ifdef SSD_CAP_DP_EN
        dp_out <= shadow_dp;
`endif
      end
      seen      <= (frame_done ? 8'h00 : seen) | (latch ? (8'h01 << idx) : 8'h00);
      seg_err   <= (latch && !dec_valid) || (seg_err && !err_clr);
      anode_err <= bad_anode || (anode_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_ssd_capture.sv
// Randomized bench for ssd_capture with a run-length behavioural model and directed literal checks.
module tb_ssd_capture;

  localparam int S = 16;
`ifdef SSD_CAP_DP_EN
  localparam logic [7:0] CMASK = 8'hFF;
`else
  localparam logic [7:0] CMASK = 8'h7F;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  anode = 8'hFF;
  logic [7:0]  cathode = 8'hFF;
  logic        err_clr = 1'b0;
  logic [31:0] digits;
  logic [7:0]  blank;
  logic        frame_valid, seg_err, anode_err;
`ifdef SSD_CAP_DP_EN
  logic [7:0]  dp_out;
`endif

  always #5 clk = ~clk;

  ssd_capture #(.SETTLE_CYCLES(S), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .anode       (anode),
    .cathode     (cathode),
    .err_clr     (err_clr),
    .digits      (digits),
    .blank       (blank),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .anode_err   (anode_err)
`ifdef SSD_CAP_DP_EN
    ,
    .dp_out      (dp_out)
`endif
  );

  logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int total = 0;
  int bad   = 0;
  int fv_cnt = 0;
  bit rand_clr_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a stable run of S+1 sampled cycles that began with a change settles one cycle later
  logic [31:0] m_digits = '0, m_shadow = '0;
  logic [7:0]  m_blank = '0, m_shadow_blank = '0, m_seen = '0;
  logic [7:0]  m_dp = '0, m_shadow_dp = '0;
  logic        m_fv = 1'b0, m_seg_err = 1'b0, m_anode_err = 1'b0;
  logic        frame_pend = 1'b0;
  logic        pend_latch = 1'b0, pend_segerr = 1'b0, pend_anerr = 1'b0, pend_blank = 1'b0, pend_dp = 1'b0;
  int          pend_idx = 0;
  logic [3:0]  pend_nib = '0;
  logic [15:0] last_val = {8'hFF, 8'hFF & CMASK};
  int          runlen = 0;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    logic [15:0] cur;
    logic [6:0]  seg7;
    logic        set_seg, found;
    cur  = {anode, cathode & CMASK};
    m_fv = 1'b0;
    if (frame_pend) begin
      m_digits = m_shadow;
      m_blank  = m_shadow_blank;
      m_dp     = m_shadow_dp;
      m_fv     = 1'b1;
      m_seen   = '0;
    end
    set_seg = 1'b0;
    if (pend_latch) begin
      m_shadow[4*pend_idx +: 4]  = pend_nib;
      m_shadow_blank[pend_idx]   = pend_blank;
      m_shadow_dp[pend_idx]      = pend_dp;
      m_seen[pend_idx]           = 1'b1;
      set_seg = pend_segerr;
    end
    m_seg_err   = set_seg | (m_seg_err & ~err_clr);
    m_anode_err = pend_anerr | (m_anode_err & ~err_clr);
    frame_pend  = (m_seen == 8'hFF);

    if (cur != last_val) begin
      runlen = 1;
      armed  = 1'b1;
    end else if (runlen < S + 5) begin
      runlen++;
    end
    if (rst && runlen >= 2) armed = 1'b0;
    last_val = cur;

    pend_latch = 1'b0;
    pend_anerr = 1'b0;
    if (armed && runlen == S + 1) begin
      if ($onehot(~anode)) begin
        pend_latch = 1'b1;
        for (int i = 0; i < 8; i++) if (!anode[i]) pend_idx = i;
        seg7       = ~cathode[6:0];
        pend_blank = (seg7 == 7'h00);
        found      = pend_blank;
        pend_nib   = 4'd0;
        for (int k = 0; k < 16; k++) begin
          if (seg7 == seg_tbl[k]) begin
            pend_nib = 4'(k);
            found    = 1'b1;
          end
        end
        pend_segerr = !found;
        pend_dp     = ~cathode[7];
      end else if (anode != 8'hFF) begin
        pend_anerr = 1'b1;
      end
    end

    if (rst) begin
      m_digits = '0; m_blank = '0; m_dp = '0; m_fv = 1'b0;
      m_seg_err = 1'b0; m_anode_err = 1'b0; m_seen = '0;
      frame_pend = 1'b0; pend_latch = 1'b0; pend_anerr = 1'b0;
    end

    #1;
    check("digits", digits, m_digits);
    check("blank", {24'd0, blank}, {24'd0, m_blank});
    check("frame_valid", {31'd0, frame_valid}, {31'd0, m_fv});
    check("seg_err", {31'd0, seg_err}, {31'd0, m_seg_err});
    check("anode_err", {31'd0, anode_err}, {31'd0, m_anode_err});
`ifdef SSD_CAP_DP_EN
    check("dp_out", {24'd0, dp_out}, {24'd0, m_dp});
`endif
    if (frame_valid === 1'b1) fv_cnt++;
  end

  function automatic logic [7:0] cath(input logic [6:0] p);
    return ~{1'b0, p};
  endfunction

  task automatic hold(input logic [7:0] a, input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      anode   = a;
      cathode = c;
`ifndef SSD_CAP_DP_EN
      cathode[7] = 1'($urandom_range(1));
`endif
      err_clr = rand_clr_en ? ($urandom_range(63) == 0) : 1'b0;
    end
  endtask

  task automatic scan(input logic [31:0] nibs, input logic [7:0] blk, input int n_dig);
    for (int d = 0; d < n_dig; d++)
      hold(~(8'h01 << d), blk[d] ? 8'hFF : cath(seg_tbl[nibs[4*d +: 4]]), 20);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;

    // Driver-style frame: value 52 on digits 1..0
    scan(32'h00000052, 8'h00, 8);
    hold(8'hFF, 8'hFF, 5);
    check("drv_fv_cnt", fv_cnt, 1);
    check("drv_digits", digits, 32'h00000052);
    check("drv_blank", {24'd0, blank}, 32'd0);
    check("drv_errs", {30'd0, seg_err, anode_err}, 32'd0);

    scan(32'h76543210, 8'h00, 8);
    hold(8'hFF, 8'hFF, 5);
    check("scan_fv_cnt", fv_cnt, 2);
    check("scan_digits", digits, 32'h76543210);
    check("model_scan_digits", m_digits, 32'h76543210);

    hold(8'hF7, cath(7'h49), 20);
    hold(8'hFF, 8'hFF, 2);
    check("bad_seg_err", {31'd0, seg_err}, 32'd1);
    clr_pulse();
    hold(8'hFF, 8'hFF, 2);
    check("bad_seg_clr", {31'd0, seg_err}, 32'd0);

    hold(8'hF3, cath(7'h3F), 20);
    hold(8'hFF, 8'hFF, 2);
    check("anode_err_set", {31'd0, anode_err}, 32'd1);
    check("model_anode_err", {31'd0, m_anode_err}, 32'd1);
    check("anode_err_no_fv", fv_cnt, 2);
    clr_pulse();
    hold(8'hFF, 8'hFF, 2);
    check("anode_err_clr", {31'd0, anode_err}, 32'd0);

    // 10-cycle wrong pattern on digit 2 before its stable value
    for (int d = 0; d < 8; d++) begin
      if (d == 2) hold(~(8'h01 << d), cath(seg_tbl[0]), 10);
      hold(~(8'h01 << d), cath(seg_tbl[8 + d]), 20);
    end
    hold(8'hFF, 8'hFF, 5);
    check("glitch_fv_cnt", fv_cnt, 3);
    check("glitch_digits", digits, 32'hFEDCBA98);
    check("glitch_no_err", {30'd0, seg_err, anode_err}, 32'd0);

    scan(32'h000FFFFF, 8'h00, 5);
    check("partial_no_fv", fv_cnt, 3);
    do_reset();
    check("reset_digits", digits, 32'd0);
    check("reset_fv", {31'd0, frame_valid}, 32'd0);
    scan(32'h06543210, 8'h80, 7);
    hold(8'hFF, 8'hFF, 3);
    check("post_reset_7_no_fv", fv_cnt, 3);
    scan(32'h06543210, 8'h80, 8);
    hold(8'hFF, 8'hFF, 5);
    check("post_reset_fv_cnt", fv_cnt, 4);
    check("post_reset_digits", digits, 32'h06543210);
    check("post_reset_blank", {24'd0, blank}, 32'h80);
    check("model_post_reset_blank", {24'd0, m_blank}, 32'h80);

    // Randomized scanning with glitches, bad anodes, bad patterns, clears and resets
    rand_clr_en = 1'b1;
    begin
      int dig;
      logic [7:0] a, c;
      dig = 0;
      for (int it = 0; it < 350; it++) begin
        int r, r2;
        r  = $urandom_range(99);
        r2 = $urandom_range(99);
        if (r < 75) begin
          dig = (r < 68) ? (dig + 1) % 8 : $urandom_range(7);
          a   = ~(8'h01 << dig);
        end else if (r < 85) begin
          a = 8'hFF;
        end else begin
          a = 8'($urandom_range(255));
        end
        if (r2 < 75)      c = cath(seg_tbl[$urandom_range(15)]);
        else if (r2 < 85) c = 8'hFF;
        else              c = 8'($urandom_range(255));
        c[7] = 1'($urandom_range(1));
        hold(a, c, $urandom_range(1, 30));
        if ($urandom_range(99) == 0) do_reset();
      end
    end
    rand_clr_en = 1'b0;
    hold(8'hFF, 8'hFF, 25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ssd_capture.md
Name: ssd_capture

Overview:
- Decoder for the multiplexed seven-segment bus. It samples the active-low anode/cathode outputs of the display driver and reconstructs the eight displayed hex nibbles.
- Used as an on-chip self-check monitor and as a bench scoreboard front end.
- Publishes each complete 8-digit frame atomically, with per-digit blank flags and sticky error flags.

Parameters:
- SETTLE_CYCLES, 16, cycles anode and cathode must hold unchanged before a digit is latched (minimum 2).
- CNT_W, 5, settle counter width; must satisfy 2^CNT_W > SETTLE_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- anode  in  8  digit enables, active-low; bit i selects digit i.
- cathode  in  8  segments, active-low; [0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g, [7]=dp.
- err_clr  in  1  one-cycle pulse; clears seg_err and anode_err.
- digits  out  32  last complete frame; nibble i = digit i.
- blank  out  8  bit i set = digit i was all segments off in the last frame.
- frame_valid  out  1  one-cycle pulse when digits/blank update.
- seg_err  out  1  sticky: a non-hex, non-blank pattern was latched.
- anode_err  out  1  sticky: anode was stable for SETTLE_CYCLES but not one-hot-low and not all-ones.

Behaviour:
- Reset, applied on a clk edge with rst=1: digits=0, blank=0, frame_valid=0, seg_err=0, anode_err=0, seen mask=0, state=IDLE, counter=0.
- Inputs are registered once (1-cycle input stage). All comparisons use the registered values.
- Segment decode is done on seg = ~cathode[6:0], with bit 0 = a.
- Hex patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - 00 = blank, nibble 0.
  - Any other pattern gives nibble 0 and sets seg_err.
- FSM:
  - IDLE: anode all-ones. Any change of the registered anode or cathode goes to SETTLE with counter=0.
  - SETTLE: counter increments each cycle while the registered anode/cathode equal the previous cycle's values. Any change restarts the counter at 0.
  - SETTLE at counter==SETTLE_CYCLES-1:
    - one-hot-low anode: latch into the shadow nibble/blank for that digit, set seen[i], go to CAPTURED.
    - all-ones anode: go to IDLE.
    - any other anode: set anode_err, go to CAPTURED.
  - CAPTURED: hold, no re-latch. Any input change goes to SETTLE with counter=0.
- Frame completion:
  - The cycle after seen becomes 8'hFF, copy shadow into digits/blank, pulse frame_valid for exactly 1 cycle, clear seen.
  - A digit recaptured before the frame completes overwrites its shadow value; the last capture wins.
- Latency: first input edge to latch = 1 (input register) + SETTLE_CYCLES cycles. Latch to frame_valid = 1 cycle.
- err_clr coinciding with a new error: the error wins and the flag stays set.
- rst mid-SETTLE or mid-frame: shadow, seen, and counter are discarded. No frame_valid is issued for the partial frame.
- Glitch shorter than SETTLE_CYCLES: no latch, no error.

Optional Feature:
- SSD_CAP_DP_EN defined:
  - Extra output port dp_out [7:0]; bit i = ~cathode[7] latched with digit i.
  - dp_out updates with the frame; reset value 0.
- Undefined:
  - No dp_out port; cathode[7] is ignored for both decode and stability comparison.

Decomposition:
- Shared package ssd_pkg: FSM state typedef (IDLE, SETTLE, CAPTURED), the 16 segment pattern constants, and SEG_BLANK.
- One sub-module, seg_to_hex: combinational 7-bit pattern to {valid, blank, nibble[3:0]}. It is the inverse of the existing hex-to-segment decoder.

Test Plan:
- Drive the display driver with switches=16'h1234 → frame_valid pulses; digits nibbles decode the BCD of 0x34 (52) = 32'h00000052 in the driver's digit order; blank=0; no errors.
- Scan digits 0..7 with patterns 3F,06,5B,4F,66,6D,7D,07, each held 20 cycles → one frame_valid; digits=32'h76543210.
- Hold digit 3 with pattern 0x49 for 20 cycles → seg_err=1, nibble 3=0. err_clr pulse → seg_err=0.
- anode=8'b11110011 held 20 cycles → anode_err=1, seen unchanged, no frame_valid.
- 10-cycle glitch on digit 2 mid-scan (SETTLE_CYCLES=16) → no latch, frame still completes with the stable values.
- Assert rst after 5 of 8 digits are captured, then scan all 8 → exactly one frame_valid, after the full post-reset scan.
